// File: rtl/register_access_ctrl.sv
// register_access_ctrl: request/response front end for the 256-bit matrix register.
// It queues read and write requests, drives the register's Enable, ReadWrite and
// DataIn pins from flops, and returns captured read data on a valid/ready port.
// Optional feature: define REG_ACC_SHADOW_EN to keep a shadow copy of the last
// written word. Reads are then served from the shadow without touching the register.
module register_access_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  Clock_i,
    input  logic                  Reset_i,
    input  logic                  ReqValid_i,
    output logic                  ReqReady_o,
    input  logic                  ReqWrite_i,
    input  logic [DATA_WIDTH-1:0] ReqData_i,
    output logic                  RspValid_o,
    input  logic                  RspReady_i,
    output logic [DATA_WIDTH-1:0] RspData_o,
    output logic                  RegEnable_o,
    output logic                  RegReadWrite_o,
    output logic [DATA_WIDTH-1:0] RegDataIn_o,
    input  logic [DATA_WIDTH-1:0] RegDataOut_i,
    output logic                  Busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic                  q_wr_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  push;
    logic                  pop;
    logic                  head_wr;
    logic [DATA_WIDTH-1:0] head_data;

    logic [2:0]            state_q, state_d;
    logic                  en_q, en_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
`ifdef REG_ACC_SHADOW_EN
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic                  shadow_vld_q, shadow_vld_d;
    logic                  shadow_hit_q, shadow_hit_d;
`endif

    // The head is popped only while idle; a pop in the same cycle lets a full queue accept.
    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign ReqReady_o = (count_q != CNT_FULL) || pop;
    assign push       = ReqValid_i && ReqReady_o;
    assign head_wr    = q_wr_q[rd_ptr_q];
    assign head_data  = q_data_q[rd_ptr_q];

    // Request queue: circular buffer with wrapping pointers and an occupancy count.
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_wr_q[i]   <= 1'b0;
                q_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                q_wr_q[wr_ptr_q]   <= ReqWrite_i;
                q_data_q[wr_ptr_q] <= ReqData_i;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer next state: one cycle per write, RD1/RD2 then RESP per read.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        rw_d       = rw_q;
        din_d      = din_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_data_d = rsp_data_q;
`ifdef REG_ACC_SHADOW_EN
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        shadow_hit_d = shadow_hit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head_wr) begin
                        state_d = S_WR;
                        en_d    = 1'b1;
                        rw_d    = 1'b0;
                        din_d   = head_data;
`ifdef REG_ACC_SHADOW_EN
                        shadow_d     = head_data;
                        shadow_vld_d = 1'b1;
`endif
                    end else begin
`ifdef REG_ACC_SHADOW_EN
                        if (shadow_vld_q) begin
                            // Served from the shadow: pass through RD2 with the register idle.
                            state_d      = S_RD2;
                            en_d         = 1'b0;
                            rw_d         = 1'b0;
                            shadow_hit_d = 1'b1;
                        end else begin
                            state_d = S_RD1;
                            en_d    = 1'b1;
                            rw_d    = 1'b1;
                        end
`else
                        state_d = S_RD1;
                        en_d    = 1'b1;
                        rw_d    = 1'b1;
`endif
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
            S_RD1: begin
                // Enable stays high so DataOut is still driven when it is captured.
                state_d = S_RD2;
            end
            S_RD2: begin
`ifdef REG_ACC_SHADOW_EN
                rsp_data_d   = shadow_hit_q ? shadow_q : RegDataOut_i;
                shadow_hit_d = 1'b0;
`else
                rsp_data_d = RegDataOut_i;
`endif
                rsp_vld_d = 1'b1;
                en_d      = 1'b0;
                rw_d      = 1'b0;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (RspReady_i) begin
                    rsp_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                rw_d    = 1'b0;
            end
        endcase
    end

    // Sequencer and register-pin flops; reset drops Enable at once.
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            rw_q       <= 1'b0;
            din_q      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
`ifdef REG_ACC_SHADOW_EN
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            shadow_hit_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            rw_q       <= rw_d;
            din_q      <= din_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
`ifdef REG_ACC_SHADOW_EN
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            shadow_hit_q <= shadow_hit_d;
`endif
        end
    end

    assign RegEnable_o    = en_q;
    assign RegReadWrite_o = rw_q;
    assign RegDataIn_o    = din_q;
    assign RspValid_o     = rsp_vld_q;
    assign RspData_o      = rsp_data_q;
    assign Busy_o         = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_register_access_ctrl.sv
// Bench for register_access_ctrl: a behavioural matrix register model, a
// transaction-level reference (last written value, in-order response queue),
// directed timing scenarios and a randomized traffic phase.
module tb_register_access_ctrl;

    localparam int DW = 256;
    localparam int FD = 2;
    localparam logic [DW-1:0] PRELOAD  = {32{8'hA5}};
    localparam logic [DW-1:0] REG_IDLE = {8{32'hDEADBEEF}};
    localparam logic [DW-1:0] PAT_X    = {4{64'h0123456789ABCDEF}};

    logic          clk;
    logic          Reset;
    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWrite;
    logic [DW-1:0] ReqData;
    logic          RspValid;
    logic          RspReady;
    logic [DW-1:0] RspData;
    logic          RegEnable;
    logic          RegReadWrite;
    logic [DW-1:0] RegDataIn;
    logic [DW-1:0] RegDataOut;
    logic          Busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    register_access_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .Clock_i        (clk),
        .Reset_i        (Reset),
        .ReqValid_i     (ReqValid),
        .ReqReady_o     (ReqReady),
        .ReqWrite_i     (ReqWrite),
        .ReqData_i      (ReqData),
        .RspValid_o     (RspValid),
        .RspReady_i     (RspReady),
        .RspData_o      (RspData),
        .RegEnable_o    (RegEnable),
        .RegReadWrite_o (RegReadWrite),
        .RegDataIn_o    (RegDataIn),
        .RegDataOut_i   (RegDataOut),
        .Busy_o         (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Matrix register: no reset; DataOut is driven only after a read-enabled edge,
    // otherwise a junk pattern stands in for the floating bus.
    logic [DW-1:0] reg_mem  = PRELOAD;
    logic [DW-1:0] reg_dout = '0;
    logic          reg_drv  = 1'b0;
    always @(posedge clk) begin
        if (RegEnable) begin
            if (RegReadWrite) reg_dout <= reg_mem;
            else              reg_mem  <= RegDataIn;
        end
        reg_drv <= RegEnable && RegReadWrite;
    end
    assign RegDataOut = reg_drv ? reg_dout : REG_IDLE;

    // Reference: every accepted write becomes the register value and must appear on
    // the register pins in order; every accepted read returns the value current at accept.
    logic [DW-1:0] model_reg = PRELOAD;
    logic [DW-1:0] exp_rsp_q[$];
    logic [DW-1:0] exp_wr_q[$];
    logic          prev_vld  = 1'b0;
    logic          prev_rdy  = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (Reset) begin
            exp_rsp_q.delete();
            exp_wr_q.delete();
            prev_vld <= 1'b0;
        end else begin
            if (ReqValid && ReqReady) begin
                if (ReqWrite) begin
                    model_reg <= ReqData;
                    exp_wr_q.push_back(ReqData);
                end else begin
                    exp_rsp_q.push_back(model_reg);
                end
            end
            if (RegEnable && !RegReadWrite) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 256'(exp_wr_q.size()), 256'd1);
                else                      chk("reg_write", RegDataIn, exp_wr_q.pop_front());
            end
            if (prev_vld && !prev_rdy) begin
                chk("rsp_hold_vld", 256'(RspValid), 256'd1);
                chk("rsp_hold_data", RspData, prev_data);
            end
            if (RspValid && RspReady) begin
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 256'(exp_rsp_q.size()), 256'd1);
                else                       chk("rsp_data", RspData, exp_rsp_q.pop_front());
            end
            prev_vld  <= RspValid;
            prev_rdy  <= RspReady;
            prev_data <= RspData;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [DW-1:0] d);
        logic acc;
        acc      = 1'b0;
        ReqValid = 1'b1;
        ReqWrite = w;
        ReqData  = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = ReqReady;
            tick();
        end
        ReqValid = 1'b0;
        if (!acc) chk("req_accept", 256'(acc), 256'd1);
    endtask

    task automatic drain();
        ReqValid = 1'b0;
        RspReady = 1'b1;
        for (int i = 0; i < 200 && Busy; i++) tick();
        tick();
        chk("drain_busy", 256'(Busy), 256'd0);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] pat_y;
        Reset    = 1'b1;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqData  = '0;
        RspReady = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();

        // Reset state
        chk("rst_req_ready", 256'(ReqReady), 256'd1);
        chk("rst_rsp_valid", 256'(RspValid), 256'd0);
        chk("rst_rsp_data", RspData, '0);
        chk("rst_reg_en", 256'(RegEnable), 256'd0);
        chk("rst_reg_rw", 256'(RegReadWrite), 256'd0);
        chk("rst_reg_din", RegDataIn, '0);
        chk("rst_busy", 256'(Busy), 256'd0);

        // Read with no prior write: returns the preloaded register content via RD1/RD2
        issue(1'b0, '0);
        chk("rd0_e0_en", 256'(RegEnable), 256'd0);
        tick();
        chk("rd0_e1_en", 256'(RegEnable), 256'd1);
        chk("rd0_e1_rw", 256'(RegReadWrite), 256'd1);
        tick();
        chk("rd0_e2_en", 256'(RegEnable), 256'd1);
        chk("rd0_e2_vld", 256'(RspValid), 256'd0);
        tick();
        chk("rd0_e3_en", 256'(RegEnable), 256'd0);
        chk("rd0_e3_vld", 256'(RspValid), 256'd1);
        chk("rd0_e3_data", RspData, PRELOAD);
        tick();
        chk("rd0_e4_vld", 256'(RspValid), 256'd0);

        // Asynchronous reset in the middle of RD1
        issue(1'b0, '0);
        tick();
        chk("rd1_en_before_rst", 256'(RegEnable), 256'd1);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_reg_en", 256'(RegEnable), 256'd0);
        chk("midrst_req_ready", 256'(ReqReady), 256'd1);
        chk("midrst_busy", 256'(Busy), 256'd0);
        tick();
        tick();
        Reset = 1'b0;
        repeat (5) tick();
        chk("midrst_rsp_valid", 256'(RspValid), 256'd0);

        // Write a pattern, then read it back
        issue(1'b1, PAT_X);
        chk("wr_e0_en", 256'(RegEnable), 256'd0);
        tick();
        chk("wr_e1_en", 256'(RegEnable), 256'd1);
        chk("wr_e1_rw", 256'(RegReadWrite), 256'd0);
        chk("wr_e1_din", RegDataIn, PAT_X);
        tick();
        chk("wr_e2_en", 256'(RegEnable), 256'd0);
        chk("wr_e2_din_hold", RegDataIn, PAT_X);
        issue(1'b0, '0);
`ifdef REG_ACC_SHADOW_EN
        tick();
        chk("shrd_e1_en", 256'(RegEnable), 256'd0);
        chk("shrd_e1_vld", 256'(RspValid), 256'd0);
        tick();
        chk("shrd_e2_en", 256'(RegEnable), 256'd0);
        chk("shrd_e2_vld", 256'(RspValid), 256'd1);
        chk("shrd_e2_data", RspData, PAT_X);
`else
        tick();
        chk("rdx_e1_en", 256'(RegEnable), 256'd1);
        chk("rdx_e1_rw", 256'(RegReadWrite), 256'd1);
        tick();
        chk("rdx_e2_en", 256'(RegEnable), 256'd1);
        chk("rdx_e2_rw", 256'(RegReadWrite), 256'd1);
        tick();
        chk("rdx_e3_en", 256'(RegEnable), 256'd0);
        chk("rdx_e3_vld", 256'(RspValid), 256'd1);
        chk("rdx_e3_data", RspData, PAT_X);
`endif
        tick();
        chk("rdx_taken_vld", 256'(RspValid), 256'd0);

        // Back-pressure with three requests pending; queue fills and holds
        pat_y    = rnd_word();
        RspReady = 1'b0;
        issue(1'b0, '0);
        issue(1'b1, pat_y);
        issue(1'b0, '0);
        chk("bp_req_ready", 256'(ReqReady), 256'd0);
        repeat (10) tick();
        chk("bp_req_ready_hold", 256'(ReqReady), 256'd0);
        chk("bp_rsp_valid", 256'(RspValid), 256'd1);
        chk("bp_rsp_data", RspData, PAT_X);

        // Release: the idle pop frees a slot, so a full queue accepts in the same cycle
        RspReady = 1'b1;
        tick();
        chk("full_pop_ready", 256'(ReqReady), 256'd1);
        chk("full_pop_busy", 256'(Busy), 256'd1);
        ReqValid = 1'b1;
        ReqWrite = 1'b0;
        ReqData  = '0;
        tick();
        ReqValid = 1'b0;
        chk("full_swap_ready", 256'(ReqReady), 256'd0);
        drain();

        // Randomized traffic with random response back-pressure
        for (int c = 0; c < 500; c++) begin
            ReqValid = ($urandom_range(0, 2) != 0);
            ReqWrite = $urandom_range(0, 1) == 1;
            ReqData  = rnd_word();
            RspReady = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        chk("end_rsp_pending", 256'(exp_rsp_q.size()), 256'd0);
        chk("end_wr_pending", 256'(exp_wr_q.size()), 256'd0);
        chk("end_req_ready", 256'(ReqReady), 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
